// File: rtl/vector_add_vector_seq.sv
// Sequential signed vector adder: accepts a whole vector pair, then works
// through it LANES elements per beat. Modes ADD/SUB/ACC/LOAD, optional
// saturation, sticky per-vector overflow flag. The result register doubles
// as the accumulator for ACC.

// One adder lane: sign-extended WIDTH+1 arithmetic with wrap or clamp.
module vector_add_vector_seq_lane #(
  parameter int WIDTH = 32,
  parameter int SAT   = 0
) (
  input  logic [1:0]       i_mode,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic [WIDTH-1:0] i_acc,
  output logic [WIDTH-1:0] o_res,
  output logic             o_ovf
);
  localparam logic [WIDTH-1:0] MAXV = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] MINV = {1'b1, {(WIDTH-1){1'b0}}};

  logic [WIDTH:0] w_x, w_y, w_z, w_sum;

  // Mode select, overflow when the two top bits disagree, then wrap/clamp.
  always_comb begin
    w_x = {i_a[WIDTH-1], i_a};
    w_y = {i_b[WIDTH-1], i_b};
    w_z = {i_acc[WIDTH-1], i_acc};
    case (i_mode)
      2'b00:   w_sum = w_x + w_y;
      2'b01:   w_sum = w_x - w_y;
      2'b10:   w_sum = w_z + w_x;
      default: w_sum = w_x;             // LOAD: sign extension cannot overflow
    endcase
    o_ovf = w_sum[WIDTH] ^ w_sum[WIDTH-1];
    if ((SAT != 0) && o_ovf) o_res = w_sum[WIDTH] ? MINV : MAXV;
    else                     o_res = w_sum[WIDTH-1:0];
  end
endmodule

module vector_add_vector_seq #(
  parameter int WIDTH = 32,
  parameter int LEN   = 5,
  parameter int LANES = 1,
  parameter int SAT   = 0
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_in_valid,
  output logic             o_in_ready,
  input  logic [1:0]       i_mode,
  input  logic [WIDTH-1:0] i_a [0:LEN-1],
  input  logic [WIDTH-1:0] i_b [0:LEN-1],
  output logic             o_out_valid,
  input  logic             i_out_ready,
  output logic [WIDTH-1:0] o_result [0:LEN-1],
  output logic             o_ovf
);
  localparam int BEATS = (LEN + LANES - 1) / LANES;
  localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int IW    = (LEN > 1) ? $clog2(LEN) : 1;

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  state_t           r_state;
  logic [BW-1:0]    r_beat;
  logic [1:0]       r_mode;
  logic [WIDTH-1:0] r_a      [0:LEN-1];
  logic [WIDTH-1:0] r_b      [0:LEN-1];
  logic [WIDTH-1:0] r_result [0:LEN-1];
  logic             r_ovf_work;
  logic             r_out_valid;

  logic                        w_accept;
  logic                        w_last;
  logic [LANES-1:0]            w_act;
  logic [LANES-1:0]            w_ovf;
  logic [LANES-1:0][IW-1:0]    w_sel;
  logic [LANES-1:0][WIDTH-1:0] w_res;

  // Ready in IDLE, or in DONE when the consumer drains this cycle (back-to-back).
  assign o_in_ready  = (r_state == S_IDLE) | ((r_state == S_DONE) & i_out_ready);
  assign w_accept    = i_in_valid & o_in_ready;
  assign w_last      = (r_beat == BW'(BEATS - 1));
  assign o_out_valid = r_out_valid;
  assign o_ovf       = r_ovf_work;
  assign o_result    = r_result;

  // Lane l handles element beat*LANES+l; lanes past LEN-1 on the last beat idle.
  for (genvar l = 0; l < LANES; l++) begin : g_lane
    logic [31:0] w_idx;
    assign w_idx    = 32'(r_beat) * 32'(LANES) + 32'(l);
    assign w_act[l] = (w_idx < 32'(LEN));
    assign w_sel[l] = w_act[l] ? w_idx[IW-1:0] : '0;

    vector_add_vector_seq_lane #(.WIDTH(WIDTH), .SAT(SAT)) u_lane (
      .i_mode (r_mode),
      .i_a    (r_a[w_sel[l]]),
      .i_b    (r_b[w_sel[l]]),
      .i_acc  (r_result[w_sel[l]]),
      .o_res  (w_res[l]),
      .o_ovf  (w_ovf[l])
    );
  end

  // Control FSM, operand capture and beat-by-beat result/overflow update.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state     <= S_IDLE;
      r_beat      <= '0;
      r_mode      <= 2'b00;
      r_ovf_work  <= 1'b0;
      r_out_valid <= 1'b0;
      for (int i = 0; i < LEN; i++) begin
        r_a[i]      <= '0;
        r_b[i]      <= '0;
        r_result[i] <= '0;
      end
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (w_accept) begin
            r_a         <= i_a;
            r_b         <= i_b;
            r_mode      <= i_mode;
            r_beat      <= '0;
            r_ovf_work  <= 1'b0;
            r_out_valid <= 1'b0;
            r_state     <= S_BUSY;
          end else if ((r_state == S_DONE) && i_out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        S_BUSY: begin
          for (int l = 0; l < LANES; l++)
            if (w_act[l]) r_result[w_sel[l]] <= w_res[l];
          r_ovf_work <= r_ovf_work | (|(w_ovf & w_act));
          if (w_last) begin
            r_out_valid <= 1'b1;
            r_state     <= S_DONE;
          end else begin
            r_beat <= r_beat + 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_vector_add_vector_seq.sv
// Directed bench: four instances share one stimulus stream
//   u1: WIDTH=32 LANES=1 wrap   u2: WIDTH=32 LANES=2 wrap
//   u3: WIDTH=8  LANES=1 wrap   u4: WIDTH=8  LANES=1 saturate
module tb_vector_add_vector_seq;
  localparam logic [1:0] ADD = 2'b00, SUB = 2'b01, ACC = 2'b10, LOAD = 2'b11;

  logic        clk = 1'b0;
  logic        rst, in_valid, out_ready;
  logic [1:0]  mode;
  logic [31:0] a [0:4];
  logic [31:0] b [0:4];
  logic [7:0]  a8 [0:4];
  logic [7:0]  b8 [0:4];

  logic        rdy1, vld1, ovf1, rdy2, vld2, ovf2, rdy3, vld3, ovf3, rdy4, vld4, ovf4;
  logic [31:0] res1 [0:4];
  logic [31:0] res2 [0:4];
  logic [7:0]  res3 [0:4];
  logic [7:0]  res4 [0:4];

  int n_tests = 0, n_fail = 0;
  int lat1, lat2, lat3, lat4, bad;

  always #5 clk = ~clk;

  // Narrow instances see the low byte of the shared operands.
  always_comb begin
    for (int i = 0; i < 5; i++) begin
      a8[i] = a[i][7:0];
      b8[i] = b[i][7:0];
    end
  end

  vector_add_vector_seq #(.WIDTH(32), .LEN(5), .LANES(1), .SAT(0)) u1 (
    .i_clk(clk), .i_rst(rst), .i_in_valid(in_valid), .o_in_ready(rdy1), .i_mode(mode),
    .i_a(a), .i_b(b), .o_out_valid(vld1), .i_out_ready(out_ready), .o_result(res1), .o_ovf(ovf1));
  vector_add_vector_seq #(.WIDTH(32), .LEN(5), .LANES(2), .SAT(0)) u2 (
    .i_clk(clk), .i_rst(rst), .i_in_valid(in_valid), .o_in_ready(rdy2), .i_mode(mode),
    .i_a(a), .i_b(b), .o_out_valid(vld2), .i_out_ready(out_ready), .o_result(res2), .o_ovf(ovf2));
  vector_add_vector_seq #(.WIDTH(8), .LEN(5), .LANES(1), .SAT(0)) u3 (
    .i_clk(clk), .i_rst(rst), .i_in_valid(in_valid), .o_in_ready(rdy3), .i_mode(mode),
    .i_a(a8), .i_b(b8), .o_out_valid(vld3), .i_out_ready(out_ready), .o_result(res3), .o_ovf(ovf3));
  vector_add_vector_seq #(.WIDTH(8), .LEN(5), .LANES(1), .SAT(1)) u4 (
    .i_clk(clk), .i_rst(rst), .i_in_valid(in_valid), .o_in_ready(rdy4), .i_mode(mode),
    .i_a(a8), .i_b(b8), .o_out_valid(vld4), .i_out_ready(out_ready), .o_result(res4), .o_ovf(ovf4));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic setv(input int x0, x1, x2, x3, x4, y0, y1, y2, y3, y4);
    a[0] = x0; a[1] = x1; a[2] = x2; a[3] = x3; a[4] = x4;
    b[0] = y0; b[1] = y1; b[2] = y2; b[3] = y3; b[4] = y4;
  endtask

  // Present one pair to every instance (all idle), hold out_ready low and
  // record the edge count at which each out_valid first appears.
  task automatic run_op(input logic [1:0] m);
    @(negedge clk);
    mode = m; in_valid = 1'b1; out_ready = 1'b0;
    lat1 = 0; lat2 = 0; lat3 = 0; lat4 = 0;
    for (int c = 1; c <= 30; c++) begin
      @(posedge clk); #1;
      if (c == 1) in_valid = 1'b0;
      if (vld1 && lat1 == 0) lat1 = c;
      if (vld2 && lat2 == 0) lat2 = c;
      if (vld3 && lat3 == 0) lat3 = c;
      if (vld4 && lat4 == 0) lat4 = c;
      if (lat1 != 0 && lat2 != 0 && lat3 != 0 && lat4 != 0) break;
    end
    if (lat1 == 0 || lat2 == 0 || lat3 == 0 || lat4 == 0) chk("timeout", 0, 1);
  endtask

  task automatic release_out();
    @(negedge clk); out_ready = 1'b1;
    @(posedge clk); #1; out_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; mode = ADD;
    setv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", rdy1, 1);
    chk("rst_out_valid", vld1, 0);
    chk("rst_ovf", ovf1, 0);
    for (int i = 0; i < 5; i++) chk($sformatf("rst_res%0d", i), res1[i], 0);
    @(negedge clk); rst = 1'b0;

    // ADD, latency BEATS+1 counted from the accept cycle
    setv(1, 2, 3, 4, 5, 10, 20, 30, 40, 50);
    run_op(ADD);
    chk("add_lat_l1", lat1, 6);
    chk("add_lat_l2", lat2, 4);
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("add_res%0d", i), res1[i], 32'(11 * (i + 1)));
      chk($sformatf("add_l2_res%0d", i), res2[i], 32'(11 * (i + 1)));
    end
    chk("add_ovf", ovf1, 0);
    release_out();

    // SUB with two lanes, then LOAD to exercise the masked last beat
    setv(0, 0, 0, 0, 0, 1, 2, 3, 4, 5);
    run_op(SUB);
    chk("sub_lat_l2", lat2, 4);
    for (int i = 0; i < 5; i++) chk($sformatf("sub_res%0d", i), res2[i], -32'(i + 1));
    release_out();
    setv(9, 9, 9, 9, 9, 7, 7, 7, 7, 7);
    run_op(LOAD);
    for (int i = 0; i < 5; i++) chk($sformatf("load_res%0d", i), res2[i], 32'd9);
    chk("load_ovf", ovf2, 0);
    release_out();

    // 8-bit positive overflow: wrap vs clamp
    setv(127, 0, 0, 0, 0, 1, 0, 0, 0, 0);
    run_op(ADD);
    chk("wrap_pos", res3[0], 32'h80);
    chk("wrap_pos_ovf", ovf3, 1);
    chk("sat_pos", res4[0], 32'h7f);
    chk("sat_pos_ovf", ovf4, 1);
    chk("w32_no_ovf", ovf1, 0);
    release_out();
    // 8-bit negative overflow: -128 + -1
    setv(-128, 0, 0, 0, 0, -1, 0, 0, 0, 0);
    run_op(ADD);
    chk("wrap_neg", res3[0], 32'h7f);
    chk("sat_neg", res4[0], 32'h80);
    chk("sat_neg_ovf", ovf4, 1);
    release_out();
    // clean add clears the flag
    setv(3, 0, 0, 0, 0, 4, 0, 0, 0, 0);
    run_op(ADD);
    chk("clean_ovf_wrap", ovf3, 0);
    chk("clean_ovf_sat", ovf4, 0);
    chk("clean_sat_res", res4[0], 32'd7);
    release_out();

    // LOAD then ACC twice; b is random and must not matter
    setv(1, 1, 1, 1, 1, 0, 0, 0, 0, 0);
    run_op(LOAD);
    release_out();
    for (int k = 0; k < 2; k++) begin
      setv(2, 3, 4, 5, 6, $urandom, $urandom, $urandom, $urandom, $urandom);
      run_op(ACC);
      release_out();
    end
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("acc_res%0d", i), res1[i], 32'(2 * i + 5));
      chk($sformatf("acc_l2_res%0d", i), res2[i], 32'(2 * i + 5));
    end

    // Backpressure for 10 cycles, then back-to-back accept on drain
    setv(1, 2, 3, 4, 5, 0, 0, 0, 0, 0);
    run_op(ADD);
    bad = 0;
    repeat (10) begin
      @(posedge clk); #1;
      if (!vld1 || rdy1 || res1[0] != 1 || res1[4] != 5) bad++;
    end
    chk("hold_stable", bad, 0);
    @(negedge clk);
    setv(100, 101, 102, 103, 104, 0, 0, 0, 0, 0);
    mode = ADD; in_valid = 1'b1; out_ready = 1'b1;
    #1;
    chk("b2b_in_ready", rdy1, 1);
    lat1 = 0;
    for (int c = 1; c <= 30; c++) begin
      @(posedge clk); #1;
      if (c == 1) begin
        in_valid = 1'b0; out_ready = 1'b0;
        chk("busy_in_ready", rdy1, 0);
      end
      if (vld1) begin lat1 = c; break; end
    end
    chk("b2b_lat", lat1, 6);
    for (int i = 0; i < 5; i++) chk($sformatf("b2b_res%0d", i), res1[i], 32'(100 + i));
    release_out();

    // Reset in the middle of an ACC aborts it and clears the accumulator
    setv(1, 2, 3, 4, 5, 0, 0, 0, 0, 0);
    @(negedge clk); mode = ACC; in_valid = 1'b1;
    @(posedge clk); #1; in_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk("abort_out_valid", vld1, 0);
    chk("abort_in_ready", rdy1, 1);
    for (int i = 0; i < 5; i++) chk($sformatf("abort_res%0d", i), res1[i], 0);
    @(negedge clk); rst = 1'b0;
    run_op(ACC);
    for (int i = 0; i < 5; i++) chk($sformatf("post_rst_acc%0d", i), res1[i], 32'(i + 1));
    release_out();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
